// File: rtl/mac_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_ctrl_pkg
// Description : Shared types and constants for the MAC array sequencer:
//               state encoding (also driven on the debug phase output),
//               west instruction bit indices and dataflow mode values.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_ctrl_pkg;

  // Sequencer states; the 3-bit value is visible on the phase debug output
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KLOAD = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Bit positions inside the 3-bit west instruction {os, execute, kflush}
  localparam int INST_OS     = 2;
  localparam int INST_EXEC   = 1;
  localparam int INST_KFLUSH = 0;

  // Dataflow mode values
  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Assemble a west instruction word from its three flags
  function automatic logic [2:0] mk_inst(input logic os, input logic exec, input logic kflush);
    logic [2:0] w_word;
    w_word              = 3'b000;
    w_word[INST_OS]     = os;
    w_word[INST_EXEC]   = exec;
    w_word[INST_KFLUSH] = kflush;
    return w_word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_array_ctrl_phase_counter.sv
`default_nettype none
// ============================================================================
// Module      : phase_counter
// Description : Down-counter for phase lengths. Loaded with (length - 1) on
//               phase entry, decremented per productive cycle; the zero flag
//               marks the last productive cycle of the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_counter #(
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [CNT_BW-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [CNT_BW-1:0] r_cnt;

  // Load takes priority over decrement so a phase hand-over reloads cleanly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec) begin
      r_cnt <= r_cnt - CNT_BW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/mac_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mac_array_ctrl
// Description : Tile-pass sequencer for the row x col MAC array. Emits the
//               west instruction {os, execute, kflush} and the L0 / IFIFO
//               read strobes. WS: KLOAD, EXEC, DRAIN. OS: EXEC, DRAIN, FLUSH.
//               All outputs are registered one cycle behind the decision.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int COL    = 8,
  parameter int CNT_BW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [CNT_BW-1:0] i_len,
  input  logic              i_l0_empty,
  input  logic              i_ififo_empty,
  output logic [2:0]        o_inst_w,
  output logic              o_l0_rd,
  output logic              o_ififo_rd,
  output logic              o_busy,
  output logic              o_done,
  output logic [2:0]        o_phase
);

  // Last counter value of each fixed-length phase
  localparam logic [CNT_BW-1:0] c_kload_last = CNT_BW'(COL - 1);
  localparam logic [CNT_BW-1:0] c_drain_last = CNT_BW'(ROW + COL - 2);
  localparam logic [CNT_BW-1:0] c_flush_last = CNT_BW'(ROW - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_mode;
  logic [CNT_BW-1:0] r_len;
  logic              w_load;
  logic [CNT_BW-1:0] w_load_val;
  logic              w_dec;
  logic              w_zero;
  logic              w_prod;
  logic [2:0]        w_inst;
  logic              w_l0_rd;
  logic              w_ififo_rd;
  logic              w_busy;
  logic              w_done;

  phase_counter #(
    .CNT_BW (CNT_BW)
  ) u_phase_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // State register plus mode/length latched when a pass is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_WS;
      r_len   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_start) begin
        r_mode <= i_mode;
        r_len  <= i_len;
      end
    end
  end

  // Next-state, counter control, stall qualification and pre-register outputs
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_prod     = 1'b0;
    w_inst     = 3'b000;
    w_l0_rd    = 1'b0;
    w_ififo_rd = 1'b0;
    w_busy     = 1'b1;
    w_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_load = 1'b1;
          if (i_mode == MODE_WS) begin
            w_next     = ST_KLOAD;
            w_load_val = c_kload_last;
          end else if (i_len != '0) begin
            w_next     = ST_EXEC;
            w_load_val = i_len - CNT_BW'(1);
          end else begin
            w_next     = ST_DRAIN;
            w_load_val = c_drain_last;
          end
        end
      end
      ST_KLOAD: begin
        w_prod  = !i_l0_empty;
        w_inst  = mk_inst(r_mode, 1'b0, w_prod);
        w_l0_rd = w_prod;
        if (w_prod) begin
          if (w_zero) begin
            w_load = 1'b1;
            if (r_len != '0) begin
              w_next     = ST_EXEC;
              w_load_val = r_len - CNT_BW'(1);
            end else begin
              w_next     = ST_DRAIN;
              w_load_val = c_drain_last;
            end
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        w_prod     = !i_l0_empty && (r_mode == MODE_WS || !i_ififo_empty);
        w_inst     = mk_inst(r_mode, w_prod, 1'b0);
        w_l0_rd    = w_prod;
        w_ififo_rd = w_prod && (r_mode == MODE_OS);
        if (w_prod) begin
          if (w_zero) begin
            w_next     = ST_DRAIN;
            w_load     = 1'b1;
            w_load_val = c_drain_last;
          end else begin
            w_dec = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        w_inst = mk_inst(r_mode, 1'b0, 1'b0);
        if (w_zero) begin
          if (r_mode == MODE_OS) begin
            w_next     = ST_FLUSH;
            w_load     = 1'b1;
            w_load_val = c_flush_last;
          end else begin
            w_next = ST_DONE;
          end
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_FLUSH: begin
        w_inst = mk_inst(r_mode, 1'b0, 1'b1);
        if (w_zero) begin
          w_next = ST_DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_DONE: begin
        w_inst = mk_inst(r_mode, 1'b0, 1'b0);
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  // Output registers: everything the array and core FSM see is flopped
  always_ff @(posedge clk) begin
    if (reset) begin
      o_inst_w   <= 3'b000;
      o_l0_rd    <= 1'b0;
      o_ififo_rd <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_phase    <= 3'b000;
    end else begin
      o_inst_w   <= w_inst;
      o_l0_rd    <= w_l0_rd;
      o_ififo_rd <= w_ififo_rd;
      o_busy     <= w_busy;
      o_done     <= w_done;
      o_phase    <= r_state;
    end
  end

endmodule
`default_nettype wire
